// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - pad-side and ALU-side signal bundle for alu_seq_ctrl
interface alu_seq_ctrl_if;
  logic       ena;
  logic [7:0] din;
  logic       load;
  logic [1:0] op_sel;
  logic       clr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_s;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       valid;
  logic       busy;
  logic [1:0] state;

  modport slave (
    input  ena, din, load, op_sel, clr, alu_result,
    output alu_a, alu_b, alu_s, result, valid, busy, state
  );

  modport master (
    output ena, din, load, op_sel, clr, alu_result,
    input  alu_a, alu_b, alu_s, result, valid, busy, state
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - operand sequencer for the 8-bit ALU on a shared data bus
// Optional accumulator chaining from DONE is enabled by defining ALU_SEQ_CHAIN_EN.
module alu_seq_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  alu_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HAVE_A = 2'b01,
    EXEC   = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [1:0] alu_s_q, alu_s_d;
  logic [7:0] result_q, result_d;
  logic       valid_q, valid_d;
  logic       load_q;
  logic       load_evt;

  // load_q tracks even when disabled so edges seen during ena=0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b1;
    end else begin
      load_q <= bus.load;
    end
  end

  assign load_evt = bus.load & ~load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_s_q  <= 2'b00;
      result_q <= 8'h00;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_s_q  <= alu_s_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (bus.ena) begin
      if (bus.clr) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (load_evt) begin
              alu_a_d = bus.din;
              state_d = HAVE_A;
            end
          end
          HAVE_A: begin
            if (load_evt) begin
              alu_b_d = bus.din;
              alu_s_d = bus.op_sel;
              state_d = EXEC;
            end
          end
          EXEC: begin
            result_d = bus.alu_result;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
          DONE: begin
            if (load_evt) begin
              valid_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
              alu_a_d = result_q;
              alu_b_d = bus.din;
              alu_s_d = bus.op_sel;
              state_d = EXEC;
`else
              alu_a_d = bus.din;
              state_d = HAVE_A;
`endif
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_s  = alu_s_q;
  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = (state_q == EXEC);
  assign bus.state  = state_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operand-sequencing controller for the 8-bit ALU (`alu_8bits`) in the TinyTapeout top level. The pad budget gives one shared 8-bit data bus, so this block collects operand A, then operand B plus the opcode, over successive load strobes. It drives them to the combinational ALU, registers the result and flags it valid. It sits between the `ui_in`/`uio_in` pads and the ALU instance, and its `result` feeds `uo_out`.

## Interface
- No parameters; all widths fixed at 8-bit data, 2-bit opcode.
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  TinyTapeout enable; low freezes the FSM and all data registers
- `din`  in  8  shared operand byte (from `ui_in`)
- `load`  in  1  operand strobe (from `uio_in[0]`), synchronous to `clk`
- `op_sel`  in  2  opcode, sampled with operand B (from `uio_in[2:1]`)
- `clr`  in  1  synchronous soft clear (from `uio_in[3]`)
- `alu_a`  out  8  registered operand A to ALU
- `alu_b`  out  8  registered operand B to ALU
- `alu_s`  out  2  registered opcode to ALU S
- `alu_result`  in  8  ALU combinational result
- `result`  out  8  registered result
- `valid`  out  1  `result` holds a completed operation
- `busy`  out  1  high in EXEC
- `state`  out  2  FSM state code, for debug on `uio_out`

## Operation
- Load event: `load` high while `load_q` is low. `load_q` is a register that updates every cycle, regardless of `ena`. One event is produced per rising edge of `load`. Holding `load` high produces no repeats.
- ALU encoding: S=00 add, 01 sub (A−B), 10 AND, 11 OR. All arithmetic is mod 256, with no carry or borrow out.
- FSM states and codes: IDLE=00, HAVE_A=01, EXEC=10, DONE=11.
  - IDLE + event: `alu_a`<=`din`, go to HAVE_A.
  - HAVE_A + event: `alu_b`<=`din`, `alu_s`<=`op_sel`, go to EXEC.
  - EXEC (unconditional, one cycle): `result`<=`alu_result`, `valid`<=1, go to DONE.
  - DONE + event: `valid`<=0, `alu_a`<=`din`, go to HAVE_A. This is the default, without chaining.
  - DONE without event: hold `result` and `valid` indefinitely.
- Priority: `clr` outranks a load event.
  - `clr`=1 with `ena`=1: go to IDLE and set `valid`<=0.
  - `alu_a`, `alu_b`, `alu_s` and `result` keep their values.
- Load events during EXEC are ignored and lost.
- `ena`=0: no state, data or `valid` change. `clr` is also ignored. `load_q` still tracks, so an edge that occurs while disabled is lost.

## Timing
- Reset values:
  - state IDLE
  - `alu_a`=`alu_b`=0, `alu_s`=0, `result`=0
  - `valid`=0, `busy`=0
  - `load_q`=1, so a `load` held high through reset does not create an event
- Reset asserted mid-operation: immediate asynchronous return to the values above. A partial operand sequence is discarded.
- Latency:
  - The B event is captured at edge k.
  - `busy`=1 during cycle k→k+1.
  - `result`/`valid` update at edge k+1.
- Minimum spacing between events is 2 cycles, because the `load` low phase needs at least 1 cycle.
- `busy` is decoded from state (state==EXEC), with no extra register.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: a DONE + event updates these registers:
  - `alu_a`<=`result`
  - `alu_b`<=`din`
  - `alu_s`<=`op_sel`
  - `valid`<=0

  It then goes directly to EXEC. This gives accumulator-style chaining with one byte per operation. The only way to start a fresh A is `clr`.
- Undefined: DONE behaves as in Operation, and a new A is loaded.

## Test plan
- Reset with `load`=1 held, release `rst_n`, hold `load` high for 5 cycles:
  - expect state=00, all outputs 0
  - expect no state change
- Load events A=0x3C, then B=0x05 with `op_sel`=01:
  - `busy`=1 for exactly 1 cycle after the B edge
  - then `result`=0x37, `valid`=1, state=11
  - values hold for 10 idle cycles
- Add overflow, A=0xF0, B=0x20, op 00:
  - expect `result`=0x10
  - then a new event in DONE gives `valid`=0, state=01, `alu_a`=new `din`
- `clr` and `load` rise in the same cycle while in HAVE_A:
  - expect state=00, `valid`=0, `alu_b` unchanged
  - expect no event to be consumed
- `ena`=0 during a `load` pulse, then `ena`=1: expect no state change and no late event. Assert `rst_n` while in EXEC: expect `result`=0, `valid`=0 immediately.
- With `ALU_SEQ_CHAIN_EN`:
  - A=0x0A, B=0x03, op 00 gives 0x0D
  - then event `din`=0x02, op 01 gives `result`=0x0B, with no A reload
